imem_access_arbiter: RTL and testbench
======================================

Name: imem_access_arbiter

Overview:
- Sequences and shares the single-port instruction memory between two requesters: the CPU fetch stage (read-only) and the program loader (write-only).
- After reset it holds the core in a BOOT phase so the loader can fill memory, then hands the port to fetch in RUN.
- In RUN the loader may still patch memory, with bounded-wait fairness.
- The memory behind it is synchronous: read data appears one cycle after the access is issued.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- MAX_WAIT, 8, max consecutive cycles a pending loader request may be denied in RUN.
- BOOT_EN, 1, 1 = reset enters BOOT; 0 = reset enters RUN directly.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  32  byte address of the instruction.
- fetch_stall  out  1  fetch request not accepted this cycle.
- fetch_valid  out  1  fetch_rdata valid this cycle.
- fetch_rdata  out  32  instruction word.
- ld_valid  in  1  loader write request.
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_ready  out  1  loader write accepted this cycle.
- ld_done  in  1  loader finished (single-cycle pulse).
- boot_mode  out  1  1 while in BOOT.
- err_addr  out  1  sticky: misaligned or out-of-range fetch seen.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- Reset:
  - Synchronous active-low reset is the only reset; rst=0 sampled at a clock edge resets all state.
  - State goes to BOOT (BOOT_EN=1) or RUN (BOOT_EN=0).
  - fetch_valid=0, fetch_rdata=0, err_addr=0, wait_cnt=0.
  - While rst=0: mem_en=0, mem_we=0, ld_ready=0, fetch_stall=1.
  - An in-flight fetch response is dropped: no fetch_valid after reset.
- Address mapping: word index = addr[ADDR_W+1:2].
  - A fetch is out of range if fetch_addr[31:ADDR_W+2] != 0; it is misaligned if fetch_addr[1:0] != 0.
  - Either condition: no memory access; fetch_valid the next cycle with fetch_rdata=32'h00000013 (NOP); err_addr set until reset.
  - Loader writes with out-of-range ld_addr are accepted (ld_ready=1) but no mem_en is issued; misaligned low bits are ignored.
- BOOT state:
  - boot_mode=1; fetch_stall=1 regardless of fetch_req; fetch is never granted.
  - ld_valid=1 → ld_ready=1 the same cycle (combinational); mem_en=1, mem_we=1, mem_addr/mem_wdata from ld_addr/ld_wdata.
  - ld_done=1 → RUN at the next edge. ld_valid and ld_done in the same cycle: the write completes, then transition.
- RUN state:
  - boot_mode=0. Fetch has priority by default.
  - Fetch granted (fetch_req=1, no forced loader grant): fetch_stall=0, mem_en=1, mem_we=0. Next cycle: fetch_valid=1, fetch_rdata=mem_rdata (1-cycle latency). Back-to-back fetches give one result per cycle.
  - fetch_req=0 and ld_valid=1: loader granted (ld_ready=1, write issued).
  - ld_valid=1 while denied: wait_cnt increments each cycle (saturates at MAX_WAIT).
  - wait_cnt==MAX_WAIT: forced loader grant that cycle. fetch_stall=1 if fetch_req; wait_cnt cleared.
  - Any loader grant clears wait_cnt. ld_valid=0 clears wait_cnt.
  - ld_done in RUN is ignored. No path back to BOOT except reset.
- Outputs and ordering:
  - fetch_valid is a single-cycle pulse per accepted fetch; fetch_rdata holds its last value otherwise.
  - A write and a fetch are never issued in the same cycle.
  - A fetch issued after a write to the same word returns the new data.

Test Plan:
- Reset/BOOT: rst=0 for 2 cycles, then rst=1 with fetch_req=1 → boot_mode=1, fetch_stall=1, mem_en=0, no fetch_valid.
- Boot load: in BOOT write ld_addr=0 data 32'h00600093, ld_addr=4 data 32'h002081B3, pulse ld_done → ld_ready=1 on each write, mem_we=1, mem_addr 0 then 1; RUN next cycle. Then fetch 0 and 4 back-to-back → fetch_valid on consecutive cycles with 32'h00600093 then 32'h002081B3.
- Starvation: in RUN hold fetch_req=1 continuously and ld_valid=1 → exactly MAX_WAIT=8 denied cycles, then 1 cycle with ld_ready=1 and fetch_stall=1; pattern repeats while both stay high.
- Bad address: fetch_addr=32'h00000006, then 32'h00001000 → fetch_valid with 32'h00000013 each time, mem_en=0 for both, err_addr=1 until reset.
- Reset mid-fetch: grant a fetch, assert rst=0 the following cycle → no fetch_valid; state returns to BOOT; err_addr=0.
- BOOT_EN=0: release reset → boot_mode=0; the first fetch of addr 0 is granted immediately with fetch_valid one cycle later.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
//   Shares one synchronous single-port instruction memory between the CPU
//   fetch stage (reads) and the program loader (writes). After reset the core
//   is held in BOOT while the loader fills memory. On ld_done the arbiter moves
//   to RUN. In RUN, fetch has priority, and a pending loader write is forced
//   through after MAX_WAIT consecutive denials.
//
//   state | meaning
//   BOOT  | loader owns the port, fetch always stalled, boot_mode=1
//   RUN   | fetch priority, loader served when idle or when starved
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   fetch_req/addr/stall         fetch request, byte address, not-accepted flag
//   fetch_valid/rdata            fetch response (1-cycle pulse), instruction word
//   ld_valid/addr/wdata/ready    loader write handshake
//   ld_done                      loader finished pulse (BOOT -> RUN)
//   boot_mode, err_addr          status; err_addr is sticky until reset
//   mem_en/we/addr/wdata/rdata   memory port, read data one cycle after issue
module imem_access_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 8,
    parameter int BOOT_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_stall,
    output logic              fetch_valid,
    output logic [31:0]       fetch_rdata,
    input  logic              ld_valid,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ready,
    input  logic              ld_done,
    output logic              boot_mode,
    output logic              err_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int          WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                rd_pend_q, rd_pend_d;
    logic                nop_pend_q, nop_pend_d;
    logic                err_addr_q, err_addr_d;
    logic [31:0]         fetch_rdata_q, fetch_rdata_d;

    logic fetch_bad;
    logic ld_oor;
    logic force_ld;

    // Loader byte-lane bits are intentionally ignored.
    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

    assign fetch_bad = (|fetch_addr[31:ADDR_W+2]) | (|fetch_addr[1:0]);
    assign ld_oor    = |ld_addr[31:ADDR_W+2];
    assign force_ld  = ld_valid && (wait_cnt_q == WAIT_W'(MAX_WAIT));

    // Responses are suppressed while reset is asserted so an in-flight read is dropped.
    assign fetch_valid = rst & (rd_pend_q | nop_pend_q);
    assign fetch_rdata = (rst && rd_pend_q)  ? mem_rdata :
                         (rst && nop_pend_q) ? NOP_INSN  : fetch_rdata_q;
    assign boot_mode   = (state_q == ST_BOOT);
    assign err_addr    = err_addr_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        rd_pend_d     = 1'b0;
        nop_pend_d    = 1'b0;
        err_addr_d    = err_addr_q;
        fetch_rdata_d = fetch_rdata;
        fetch_stall   = 1'b1;
        ld_ready      = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        if (rst) begin
            unique case (state_q)
                ST_BOOT: begin
                    if (ld_valid) begin
                        ld_ready  = 1'b1;
                        mem_en    = !ld_oor;
                        mem_we    = !ld_oor;
                        mem_addr  = ld_addr[ADDR_W+1:2];
                        mem_wdata = ld_wdata;
                    end
                    if (ld_done) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fetch_req && !force_ld) begin
                        fetch_stall = 1'b0;
                        if (fetch_bad) begin
                            nop_pend_d = 1'b1;
                            err_addr_d = 1'b1;
                        end else begin
                            mem_en    = 1'b1;
                            mem_addr  = fetch_addr[ADDR_W+1:2];
                            rd_pend_d = 1'b1;
                        end
                        if (!ld_valid) begin
                            wait_cnt_d = '0;
                        end else if (wait_cnt_q < WAIT_W'(MAX_WAIT)) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end else if (ld_valid) begin
                        ld_ready   = 1'b1;
                        mem_en     = !ld_oor;
                        mem_we     = !ld_oor;
                        mem_addr   = ld_addr[ADDR_W+1:2];
                        mem_wdata  = ld_wdata;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = '0;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= (BOOT_EN != 0) ? ST_BOOT : ST_RUN;
            wait_cnt_q    <= '0;
            rd_pend_q     <= 1'b0;
            nop_pend_q    <= 1'b0;
            err_addr_q    <= 1'b0;
            fetch_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            rd_pend_q     <= rd_pend_d;
            nop_pend_q    <= nop_pend_d;
            err_addr_q    <= err_addr_d;
            fetch_rdata_q <= fetch_rdata_d;
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter: a BOOT_EN=1 instance backed by a
// synchronous memory model, plus a BOOT_EN=0 instance for direct-to-RUN reset.
module tb_imem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fetch_req, ld_valid, ld_done;
    logic [31:0] fetch_addr, ld_addr, ld_wdata;
    logic        fetch_stall, fetch_valid, ld_ready, boot_mode, err_addr;
    logic [31:0] fetch_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;

    logic        r_fetch_req;
    logic [31:0] r_fetch_addr;
    logic        r_fetch_stall, r_fetch_valid, r_ld_ready, r_boot_mode, r_err_addr;
    logic [31:0] r_fetch_rdata, r_mem_wdata, r_mem_rdata;
    logic        r_mem_en, r_mem_we;
    logic [9:0]  r_mem_addr;

    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    imem_access_arbiter #(.ADDR_W(10), .MAX_WAIT(8), .BOOT_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
        .ld_done(ld_done), .boot_mode(boot_mode), .err_addr(err_addr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_access_arbiter #(.ADDR_W(10), .MAX_WAIT(8), .BOOT_EN(0)) u_dut_run (
        .clk(clk), .rst(rst),
        .fetch_req(r_fetch_req), .fetch_addr(r_fetch_addr), .fetch_stall(r_fetch_stall),
        .fetch_valid(r_fetch_valid), .fetch_rdata(r_fetch_rdata),
        .ld_valid(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0), .ld_ready(r_ld_ready),
        .ld_done(1'b0), .boot_mode(r_boot_mode), .err_addr(r_err_addr),
        .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata)
    );

    // Synchronous memory models: read data one cycle after issue.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (r_mem_en && !r_mem_we) r_mem_rdata <= 32'hA5A5_0000 | {22'h0, r_mem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        ld_valid = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h1234_5678; ld_done = 1'b0;
        r_fetch_req = 1'b1; r_fetch_addr = 32'h0;

        // Reset held: everything inactive even with requests pending
        mid();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_fetch_stall", 32'(fetch_stall), 32'd1);
        chk("rst_run_stall", 32'(r_fetch_stall), 32'd1);
        step();
        step();

        // Reset released into BOOT with fetch requested
        rst = 1'b1;
        ld_valid = 1'b0;
        mid();
        chk("boot_mode", 32'(boot_mode), 32'd1);
        chk("boot_stall", 32'(fetch_stall), 32'd1);
        chk("boot_mem_en", 32'(mem_en), 32'd0);
        chk("boot_valid", 32'(fetch_valid), 32'd0);
        chk("boot_rdata", fetch_rdata, 32'h0);
        chk("boot_err", 32'(err_addr), 32'd0);
        // BOOT_EN=0 instance goes straight to RUN and grants fetch of addr 0
        chk("run_boot_mode", 32'(r_boot_mode), 32'd0);
        chk("run_stall", 32'(r_fetch_stall), 32'd0);
        chk("run_mem_en", 32'(r_mem_en), 32'd1);
        step();
        r_fetch_req = 1'b0;
        mid();
        chk("boot_valid2", 32'(fetch_valid), 32'd0);
        chk("run_valid", 32'(r_fetch_valid), 32'd1);
        chk("run_rdata", r_fetch_rdata, 32'hA5A5_0000);
        step();

        // Boot load
        fetch_req = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h0060_0093;
        mid();
        chk("ld0_ready", 32'(ld_ready), 32'd1);
        chk("ld0_we", 32'(mem_we), 32'd1);
        chk("ld0_addr", 32'(mem_addr), 32'd0);
        chk("ld0_wdata", mem_wdata, 32'h0060_0093);
        step();
        ld_addr = 32'h0000_1000; ld_wdata = 32'hFFFF_FFFF;
        mid();
        chk("ld_oor_ready", 32'(ld_ready), 32'd1);
        chk("ld_oor_en", 32'(mem_en), 32'd0);
        step();
        ld_addr = 32'h4; ld_wdata = 32'h0020_81B3; ld_done = 1'b1;
        mid();
        chk("ld1_ready", 32'(ld_ready), 32'd1);
        chk("ld1_addr", 32'(mem_addr), 32'd1);
        chk("ld1_boot", 32'(boot_mode), 32'd1);
        step();
        ld_valid = 1'b0; ld_done = 1'b0;

        // RUN: back-to-back fetches
        fetch_req = 1'b1; fetch_addr = 32'h0;
        mid();
        chk("run_entered", 32'(boot_mode), 32'd0);
        chk("f0_stall", 32'(fetch_stall), 32'd0);
        chk("f0_en", 32'(mem_en), 32'd1);
        chk("f0_we", 32'(mem_we), 32'd0);
        chk("f0_addr", 32'(mem_addr), 32'd0);
        step();
        fetch_addr = 32'h4;
        mid();
        chk("f0_valid", 32'(fetch_valid), 32'd1);
        chk("f0_rdata", fetch_rdata, 32'h0060_0093);
        chk("f1_addr", 32'(mem_addr), 32'd1);
        step();
        fetch_req = 1'b0;
        mid();
        chk("f1_valid", 32'(fetch_valid), 32'd1);
        chk("f1_rdata", fetch_rdata, 32'h0020_81B3);
        step();
        mid();
        chk("idle_valid", 32'(fetch_valid), 32'd0);
        chk("idle_rdata_hold", fetch_rdata, 32'h0020_81B3);
        step();

        // Starvation: fetch and loader both held high
        fetch_req = 1'b1; fetch_addr = 32'h0;
        ld_valid = 1'b1; ld_addr = 32'h8; ld_wdata = 32'hDEAD_0001;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                mid();
                chk($sformatf("starve_r%0d_c%0d_ready", r, k), 32'(ld_ready), 32'd0);
                chk($sformatf("starve_r%0d_c%0d_stall", r, k), 32'(fetch_stall), 32'd0);
                step();
            end
            mid();
            chk($sformatf("force_r%0d_ready", r), 32'(ld_ready), 32'd1);
            chk($sformatf("force_r%0d_stall", r), 32'(fetch_stall), 32'd1);
            chk($sformatf("force_r%0d_we", r), 32'(mem_we), 32'd1);
            step();
        end
        fetch_req = 1'b0; ld_valid = 1'b0;
        step();

        // Write then immediate fetch of the same word
        ld_valid = 1'b1; ld_addr = 32'hC; ld_wdata = 32'hCAFE_0003;
        mid();
        chk("patch_ready", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 32'hC;
        step();
        fetch_req = 1'b0;
        mid();
        chk("raw_valid", 32'(fetch_valid), 32'd1);
        chk("raw_rdata", fetch_rdata, 32'hCAFE_0003);
        step();

        // Forced-write data landed too
        fetch_req = 1'b1; fetch_addr = 32'h8;
        step();
        fetch_req = 1'b0;
        mid();
        chk("starve_data", fetch_rdata, 32'hDEAD_0001);
        step();

        // Bad addresses
        fetch_req = 1'b1; fetch_addr = 32'h6;
        mid();
        chk("mis_en", 32'(mem_en), 32'd0);
        chk("mis_stall", 32'(fetch_stall), 32'd0);
        chk("mis_err_pre", 32'(err_addr), 32'd0);
        step();
        fetch_addr = 32'h0000_1000;
        mid();
        chk("mis_valid", 32'(fetch_valid), 32'd1);
        chk("mis_rdata", fetch_rdata, 32'h0000_0013);
        chk("oor_en", 32'(mem_en), 32'd0);
        chk("mis_err", 32'(err_addr), 32'd1);
        step();
        fetch_req = 1'b0;
        mid();
        chk("oor_valid", 32'(fetch_valid), 32'd1);
        chk("oor_rdata", fetch_rdata, 32'h0000_0013);
        step();
        mid();
        chk("err_sticky", 32'(err_addr), 32'd1);
        chk("nop_hold", fetch_rdata, 32'h0000_0013);
        step();

        // Reset mid-fetch
        fetch_req = 1'b1; fetch_addr = 32'h0;
        step();
        rst = 1'b0; fetch_req = 1'b0;
        mid();
        chk("rstmid_valid", 32'(fetch_valid), 32'd0);
        step();
        rst = 1'b1;
        mid();
        chk("rstmid_boot", 32'(boot_mode), 32'd1);
        chk("rstmid_err", 32'(err_addr), 32'd0);
        chk("rstmid_valid2", 32'(fetch_valid), 32'd0);
        chk("rstmid_rdata", fetch_rdata, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
